// File: rtl/counter_run_arb_pkg.sv
// Shared types and constants for the counter run arbiter.
// The watchdog limit below is only used when COUNTER_RUN_ARB_TIMEOUT_EN is defined.
package counter_run_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NREQ  = 2;
  localparam int DEF_CNT_W = 4;

  // RUN cycles allowed before a stalled run is abandoned.
  function automatic int wdog_limit(input int cnt_w);
    return (1 << cnt_w) + 2;
  endfunction

endpackage

// File: rtl/counter_run_arb_rr.sv
// Combinational round-robin picker: the first requester found after ptr,
// wrapping around, gets the one-hot pick.
module counter_run_arb_rr
  import counter_run_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick
);

  // Rank each requester by its distance from the slot after ptr; nearest wins.
  always_comb begin
    int w_best_d;
    int w_best_i;
    w_best_d = NREQ;
    w_best_i = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (((i - int'(ptr) - 1 + 2 * NREQ) % NREQ) < w_best_d)) begin
        w_best_d = (i - int'(ptr) - 1 + 2 * NREQ) % NREQ;
        w_best_i = i;
      end
    end
    pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick[i] = (w_best_d < NREQ) && (i == w_best_i);
    end
  end

endmodule

// File: rtl/counter_run_arb.sv
// Round-robin arbiter that lends one shared counter to a requester for a run of len cycles.
// Define COUNTER_RUN_ARB_TIMEOUT_EN to add a RUN-state watchdog driving timeout_err.
module counter_run_arb
  import counter_run_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  input  logic [CNT_W-1:0]      cnt_val,
  input  logic                  cnt_ovf,
  output logic [NREQ-1:0]       gnt,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  output logic [NREQ-1:0]       done,
  output logic                  ovf_err,
  output logic                  timeout_err
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_clr;
  logic             r_ovf;
  logic [CNT_W-1:0] r_len;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_win;

  logic [NREQ-1:0]  w_pick;
  logic [PTR_W-1:0] w_pick_idx;
  logic [CNT_W-1:0] w_len_sel;
  logic             w_hold;
  logic             w_in_run;
  logic             w_abort;
  logic             w_wdog_exp;

  counter_run_arb_rr #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    w_len_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
        w_len_sel  = len[i*CNT_W +: CNT_W];
      end
    end
  end

  // The winner keeps its grant only while it keeps its request high.
  assign w_hold   = |(req & r_gnt);
  assign w_in_run = (r_state == RUN);
  assign w_abort  = !w_hold || (w_in_run && (cnt_ovf || w_wdog_exp));

`ifdef COUNTER_RUN_ARB_TIMEOUT_EN
  localparam int WD_W = CNT_W + 2;
  logic [WD_W-1:0] r_wdog;
  logic            r_tmo;

  assign w_wdog_exp = w_in_run && (r_wdog == WD_W'(wdog_limit(CNT_W) - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_wdog <= w_in_run ? r_wdog + 1'b1 : '0;
      if (w_wdog_exp) r_tmo <= 1'b1;
    end
  end

  assign timeout_err = r_tmo;
`else
  assign w_wdog_exp  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_clr   <= 1'b0;
      r_ovf   <= 1'b0;
      r_len   <= '0;
      r_ptr   <= PTR_W'(NREQ - 1);
      r_win   <= '0;
    end else begin
      r_done <= '0;
      r_clr  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt   <= w_pick;
            r_win   <= w_pick_idx;
            r_len   <= w_len_sel;
            r_clr   <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR, RUN: begin
          if (w_in_run && cnt_ovf) r_ovf <= 1'b1;
          // An abort beats completion when both land in the same cycle.
          if (w_abort) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= r_win;
          end else if (w_in_run && (cnt_val == r_len)) begin
            r_state <= DONE;
            r_done  <= r_gnt;
            r_ptr   <= r_win;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign cnt_clr = r_clr;
  assign cnt_en  = w_in_run && (cnt_val != r_len);
  assign ovf_err = r_ovf;

endmodule

// File: tb/tb_counter_run_arb.sv
// Bench for counter_run_arb: directed scenarios then random traffic, all checked
// against a run-timeline model; the shared counter itself is emulated here.
module tb_counter_run_arb;

  localparam int NREQ  = 2;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] len;
  logic [CNT_W-1:0]      cnt_val;
  logic                  cnt_ovf;
  logic [NREQ-1:0]       gnt;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic [NREQ-1:0]       done;
  logic                  ovf_err;
  logic                  timeout_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: a run granted in cycle t0 has phase p = cycle - t0 (CLEAR at 1,
  // RUN at 2..2+L, DONE at 3+L); the model is idle when m_busy is 0.
  bit m_busy;
  int m_p;
  int m_L;
  int m_win;
  int m_ptr;
  bit m_ovf;

  counter_run_arb #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .len         (len),
    .cnt_val     (cnt_val),
    .cnt_ovf     (cnt_ovf),
    .gnt         (gnt),
    .cnt_clr     (cnt_clr),
    .cnt_en      (cnt_en),
    .done        (done),
    .ovf_err     (ovf_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input int v);
    len[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_p    = 0;
    m_L    = 0;
    m_win  = 0;
    m_ptr  = NREQ - 1;
    m_ovf  = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs of the current cycle.
  task automatic model_step();
    bit in_run;
    if (!m_busy) begin
      if (req != '0) begin
        m_win  = rr_pick(m_ptr, req);
        m_L    = int'(len[m_win*CNT_W +: CNT_W]);
        m_busy = 1'b1;
        m_p    = 0;
      end
    end else begin
      in_run = (m_p >= 2) && (m_p <= 2 + m_L);
      if ((m_p >= 1) && (m_p <= 2 + m_L) && (!req[m_win] || (in_run && cnt_ovf))) begin
        if (in_run && cnt_ovf) m_ovf = 1'b1;
        m_busy = 1'b0;
        m_ptr  = m_win;
      end else if (m_p == 3 + m_L) begin
        m_busy = 1'b0;
        m_ptr  = m_win;
      end
    end
    if (m_busy) m_p++;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] g_e;
    logic [NREQ-1:0] d_e;
    g_e = m_busy ? NREQ'(1 << m_win) : '0;
    d_e = (m_busy && (m_p == 3 + m_L)) ? g_e : '0;
    chk("gnt",          32'(gnt),              32'(g_e));
    chk("done",         32'(done),             32'(d_e));
    chk("cnt_clr",      32'(cnt_clr),          32'(m_busy && (m_p == 1)));
    chk("cnt_en",       32'(cnt_en),           32'(m_busy && (m_p >= 2) && (m_p <= 1 + m_L)));
    chk("ovf_err",      32'(ovf_err),          32'(m_ovf));
    chk("timeout_err",  32'(timeout_err),      32'(1'b0));
    chk("clr_en_excl",  32'(cnt_clr & cnt_en), 32'(1'b0));
    chk("gnt_onehot0",  32'($onehot0(gnt)),    32'(1'b1));
    chk("done_onehot0", 32'($onehot0(done)),   32'(1'b1));
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    logic en_s;
    logic clr_s;
    en_s  = cnt_en;
    clr_s = cnt_clr;
    model_step();
    @(posedge clk);
    #1;
    if (clr_s) cnt_val = '0;
    else if (en_s) cnt_val = cnt_val + 1'b1;
    cyc++;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req     = '0;
    cnt_ovf = 1'b0;
    reset   = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt",     32'(gnt),         32'(0));
    chk("rst_done",    32'(done),        32'(0));
    chk("rst_cnt_clr", 32'(cnt_clr),     32'(0));
    chk("rst_cnt_en",  32'(cnt_en),      32'(0));
    chk("rst_ovf_err", 32'(ovf_err),     32'(0));
    chk("rst_tmo_err", 32'(timeout_err), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget, output int lat, output int n_en,
                           output int n_clr, output logic [NREQ-1:0] g, output logic [NREQ-1:0] d);
    int t0;
    int k;
    bit seen;
    t0 = cyc;
    k = 0;
    seen = 1'b0;
    lat = -1;
    n_en = 0;
    n_clr = 0;
    g = '0;
    d = '0;
    while (!seen && (k < budget)) begin
      tick();
      k++;
      if (cnt_en) n_en++;
      if (cnt_clr) begin
        n_clr++;
        g = gnt;
      end
      if (done != '0) begin
        seen = 1'b1;
        lat = cyc - t0;
        d = done;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'(1'b1));
  endtask

  task automatic tick_until_clr(input string tag, input int budget);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && (k < budget)) begin
      tick();
      k++;
      if (cnt_clr) seen = 1'b1;
    end
    chk({tag, "_clr_seen"}, 32'(seen), 32'(1'b1));
  endtask

  initial begin
    int lat;
    int n_en;
    int n_clr;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] d;
    logic [NREQ-1:0] exp_order [4];
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset   = 1'b1;
    req     = '0;
    len     = '0;
    cnt_val = '0;
    cnt_ovf = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single run of length 5
    set_len(0, 5);
    set_len(1, 3);
    req = 2'b01;
    wait_done("single", 20, lat, n_en, n_clr, g, d);
    chk("single_latency",  32'(lat),     32'(8));
    chk("single_en_cyc",   32'(n_en),    32'(5));
    chk("single_clr_cyc",  32'(n_clr),   32'(1));
    chk("single_gnt",      32'(g),       32'(2'b01));
    chk("single_done",     32'(d),       32'(2'b01));
    chk("single_cnt_val",  32'(cnt_val), 32'(5));
    req = '0;
    tick();

    // Fairness with both requesting
    do_reset();
    set_len(0, 2);
    set_len(1, 2);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done("fair", 20, lat, n_en, n_clr, g, d);
      chk("fair_gnt",  32'(g), 32'(exp_order[k]));
      chk("fair_done", 32'(d), 32'(exp_order[k]));
    end
    req = '0;
    tick();

    // Zero-length run
    set_len(0, 0);
    req = 2'b01;
    wait_done("zero", 10, lat, n_en, n_clr, g, d);
    chk("zero_latency", 32'(lat),  32'(3));
    chk("zero_en_cyc",  32'(n_en), 32'(0));
    chk("zero_done",    32'(d),    32'(2'b01));
    req = '0;
    tick();

    // Abort by dropping req0 in the third RUN cycle
    do_reset();
    set_len(0, 6);
    set_len(1, 3);
    req = 2'b11;
    tick_until_clr("abort", 10);
    tick();
    tick();
    tick();
    req = 2'b10;
    tick();
    chk("abort_gnt",  32'(gnt),  32'(0));
    chk("abort_done", 32'(done), 32'(0));
    tick();
    chk("abort_next_gnt", 32'(gnt), 32'(2'b10));
    wait_done("abort_next", 15, lat, n_en, n_clr, g, d);
    chk("abort_next_done", 32'(d), 32'(2'b10));
    req = '0;
    tick();

    // Counter overflow during RUN
    set_len(0, 8);
    req = 2'b01;
    tick_until_clr("ovf", 10);
    tick();
    tick();
    cnt_ovf = 1'b1;
    tick();
    cnt_ovf = 1'b0;
    chk("ovf_flag", 32'(ovf_err), 32'(1));
    chk("ovf_gnt",  32'(gnt),     32'(0));
    chk("ovf_done", 32'(done),    32'(0));
    req = '0;
    tick();
    tick();
    tick();
    chk("ovf_sticky", 32'(ovf_err), 32'(1));

    // Reset in the middle of a run
    set_len(0, 7);
    req = 2'b01;
    tick_until_clr("rstmid", 10);
    tick();
    tick();
    do_reset();
    set_len(0, 1);
    set_len(1, 1);
    req = 2'b11;
    tick();
    chk("rstmid_first_gnt", 32'(gnt), 32'(2'b01));
    wait_done("rstmid_after", 10, lat, n_en, n_clr, g, d);
    chk("rstmid_done", 32'(d), 32'(2'b01));
    req = '0;
    tick();

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_busy && (i == m_win)) req[i] = ($urandom_range(0, 39) != 0);
        else if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        set_len(i, int'($urandom_range(0, 6)));
      end
      cnt_ovf = ($urandom_range(0, 59) == 0);
      tick();
    end
    req = '0;
    cnt_ovf = 1'b0;
    for (int n = 0; n < 12; n++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
